// File: rtl/dm_ws.sv
// dm_ws: byte-addressed data memory for the MEM stage with sized, sign-aware
// loads/stores, a fixed number of wait states and valid/ready handshakes.
// Little-endian: the byte at addr maps to data bits [7:0].
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   req_valid/req_ready request handshake; ready only while idle
//   req_we              1 = store, 0 = load
//   req_size            00 byte, 01 half, 10 word, 11 reserved
//   req_signed          sign-extend byte/half load results
//   req_addr            byte address
//   req_wdata           right-aligned store data
//   resp_valid/ready    response handshake
//   resp_rdata          load result (0 for stores and errors)
//   resp_err            access rejected (misaligned, reserved, out of range)
//
// state  | meaning
// S_IDLE | ready for a request; with WAIT = 0 the access commits on accept
// S_WAIT | counting down wait states; commit on the edge where cnt_q == 1
// S_RESP | holding the response until resp_ready
module dm_ws #(
  parameter int ADDR_W      = 14,
  parameter int DEPTH_BYTES = 12288,
  parameter int WAIT        = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [3:0]    WAIT_L  = 4'(WAIT);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH_BYTES);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, sgn_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [7:0] mem [DEPTH_BYTES];

  // Commit operands: straight from the request when committing on the accept
  // edge (WAIT = 0), otherwise from the latched copy.
  logic              c_we, c_sgn, commit, acc_err;
  logic [1:0]        c_size;
  logic [ADDR_W-1:0] a0, a1, a2, a3;
  logic [31:0]       c_wdata, ld_data;
  logic [2:0]        nbytes;
  logic [ADDR_W:0]   end_addr;

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  always_comb begin
    c_we    = (state_q == S_IDLE) ? req_we     : we_q;
    c_size  = (state_q == S_IDLE) ? req_size   : size_q;
    c_sgn   = (state_q == S_IDLE) ? req_signed : sgn_q;
    a0      = (state_q == S_IDLE) ? req_addr   : addr_q;
    c_wdata = (state_q == S_IDLE) ? req_wdata  : wdata_q;
    a1      = a0 + ADDR_W'(1);
    a2      = a0 + ADDR_W'(2);
    a3      = a0 + ADDR_W'(3);
    commit  = ((state_q == S_IDLE) && req_valid && (WAIT == 0)) ||
              ((state_q == S_WAIT) && (cnt_q == 4'd1));
    case (c_size)
      2'd0:    nbytes = 3'd1;
      2'd1:    nbytes = 3'd2;
      2'd2:    nbytes = 3'd4;
      default: nbytes = 3'd0;
    endcase
    // One extra bit so an access near the top cannot wrap back into range.
    end_addr = {1'b0, a0} + {{(ADDR_W-2){1'b0}}, nbytes};
    acc_err  = (c_size == 2'd3) ||
               ((c_size == 2'd1) && a0[0]) ||
               ((c_size == 2'd2) && (a0[1:0] != 2'b00)) ||
               (end_addr > DEPTH_L);
    ld_data = 32'd0;
    if (!acc_err && !c_we) begin
      case (c_size)
        2'd0: ld_data = {{24{c_sgn & mem[a0][7]}}, mem[a0]};
        2'd1: ld_data = {{16{c_sgn & mem[a1][7]}}, mem[a1], mem[a0]};
        2'd2: ld_data = {mem[a3], mem[a2], mem[a1], mem[a0]};
        default: ld_data = 32'd0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          cnt_d   = WAIT_L;
          state_d = (WAIT == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
          rdata_d = 32'd0;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (commit) begin
      rdata_d = ld_data;
      err_d   = acc_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      size_q  <= 2'd0;
      sgn_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (state_q == S_IDLE && req_valid) begin
        we_q    <= req_we;
        size_q  <= req_size;
        sgn_q   <= req_signed;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

  // Storage is intentionally not reset; reset only kills pending commits.
  always_ff @(posedge clk) begin
    if (commit && c_we && !acc_err) begin
      case (c_size)
        2'd0: mem[a0] <= c_wdata[7:0];
        2'd1: begin
          mem[a0] <= c_wdata[7:0];
          mem[a1] <= c_wdata[15:8];
        end
        2'd2: begin
          mem[a0] <= c_wdata[7:0];
          mem[a1] <= c_wdata[15:8];
          mem[a2] <= c_wdata[23:16];
          mem[a3] <= c_wdata[31:24];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_ws.sv
module tb_dm_ws;
  localparam int AW = 14;
  localparam int DEPTH = 12288;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic req_valid, req_we, req_signed, resp_ready, sel;
  logic [1:0] req_size;
  logic [AW-1:0] req_addr;
  logic [31:0] req_wdata;

  logic a_ready, a_valid, a_err, b_ready, b_valid, b_err;
  logic [31:0] a_rdata, b_rdata;
  logic m_ready, m_valid, m_err;
  logic [31:0] m_rdata;

  // u_a: WAIT = 2, u_b: WAIT = 0; sel picks which one the request goes to.
  dm_ws #(.ADDR_W(AW), .DEPTH_BYTES(DEPTH), .WAIT(2)) u_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid & ~sel), .req_ready(a_ready),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(a_valid),
    .resp_ready(resp_ready), .resp_rdata(a_rdata), .resp_err(a_err));

  dm_ws #(.ADDR_W(AW), .DEPTH_BYTES(DEPTH), .WAIT(0)) u_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid & sel), .req_ready(b_ready),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(b_valid),
    .resp_ready(resp_ready), .resp_rdata(b_rdata), .resp_err(b_err));

  assign m_ready = sel ? b_ready : a_ready;
  assign m_valid = sel ? b_valid : a_valid;
  assign m_rdata = sel ? b_rdata : a_rdata;
  assign m_err   = sel ? b_err   : a_err;

  int checks = 0;
  int errors = 0;
  logic [7:0] ref_mem [DEPTH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model for the WAIT = 2 instance: plain byte array arithmetic.
  function automatic void ref_access(input logic we, input logic [1:0] size, input logic sgn,
                                     input int addr, input logic [31:0] wd,
                                     output logic [31:0] rd, output logic e);
    int nb;
    longint v;
    nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : (size == 2'd2) ? 4 : 0;
    rd = 32'd0;
    e = (nb == 0) || ((addr % nb) != 0) || (addr + nb > DEPTH);
    if (e) return;
    if (we) begin
      for (int k = 0; k < nb; k++) ref_mem[addr+k] = 8'(wd >> (8*k));
    end else begin
      v = 0;
      for (int k = 0; k < nb; k++) v += longint'(ref_mem[addr+k]) << (8*k);
      if (sgn && nb < 4 && v >= (longint'(1) << (8*nb-1))) v -= (longint'(1) << (8*nb));
      rd = 32'(v);
    end
  endfunction

  task automatic do_req(input logic s, input logic we, input logic [1:0] size, input logic sgn,
                        input int addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic e, output int lat,
                        output logic [31:0] mrd, output logic me);
    int n;
    sel = s; req_we = we; req_size = size; req_signed = sgn;
    req_addr = AW'(addr); req_wdata = wd; req_valid = 1'b1;
    n = 0;
    while (!m_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) chk("accept_timeout", {31'd0, m_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!m_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    if (lat >= 50) chk("resp_timeout", {31'd0, m_valid}, 32'd1);
    rd = m_rdata; e = m_err;
    mrd = 32'd0; me = 1'b0;
    if (!s) ref_access(we, size, sgn, addr, wd, mrd, me);
    @(posedge clk); #1;
    chk("resp_clear", {m_valid, m_err, m_rdata[29:0]}, 32'd0);
  endtask

  task automatic dir(input string tag, input logic s, input logic we, input logic [1:0] size,
                     input logic sgn, input int addr, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    logic [31:0] rd, mrd;
    logic e, me;
    int lat;
    do_req(s, we, size, sgn, addr, wd, rd, e, lat, mrd, me);
    chk({tag, "_rdata"}, rd, exp_rd);
    chk({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
    chk({tag, "_lat"}, lat, exp_lat);
  endtask

  initial begin
    logic [31:0] rd, mrd;
    logic e, me;
    int lat, n, addr;
    logic [1:0] size;

    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = '0; req_wdata = 32'd0; resp_ready = 1'b1; sel = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {a_valid, a_err, a_rdata[29:0]}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", {31'd0, a_ready}, 32'd1);

    // Known contents for every region the bench reads.
    for (int a = 0; a < 64; a += 4) do_req(0, 1, 2'd2, 0, a, 32'd0, rd, e, lat, mrd, me);
    do_req(0, 1, 2'd2, 0, 'h100, 32'd0, rd, e, lat, mrd, me);
    do_req(0, 1, 2'd2, 0, 'h104, 32'd0, rd, e, lat, mrd, me);
    do_req(0, 1, 2'd2, 0, DEPTH-8, 32'd0, rd, e, lat, mrd, me);
    do_req(0, 1, 2'd2, 0, DEPTH-4, 32'd0, rd, e, lat, mrd, me);

    dir("sw80",  0, 1, 2'd2, 0, 'h080, 32'h8899AABB, 32'h0, 0, 2);
    dir("lw80",  0, 0, 2'd2, 0, 'h080, 32'h0, 32'h8899AABB, 0, 2);
    dir("lb83",  0, 0, 2'd0, 1, 'h083, 32'h0, 32'hFFFFFF88, 0, 2);
    dir("lbu83", 0, 0, 2'd0, 0, 'h083, 32'h0, 32'h00000088, 0, 2);
    dir("lh82",  0, 0, 2'd1, 1, 'h082, 32'h0, 32'hFFFF8899, 0, 2);
    dir("lhu80", 0, 0, 2'd1, 0, 'h080, 32'h0, 32'h0000AABB, 0, 2);
    dir("sb81",  0, 1, 2'd0, 0, 'h081, 32'h11, 32'h0, 0, 2);
    dir("lw80b", 0, 0, 2'd2, 0, 'h080, 32'h0, 32'h889911BB, 0, 2);
    dir("sh81",  0, 1, 2'd1, 0, 'h081, 32'h5555, 32'h0, 1, 2);
    dir("lw80c", 0, 0, 2'd2, 0, 'h080, 32'h0, 32'h889911BB, 0, 2);
    dir("lw_top", 0, 0, 2'd2, 0, DEPTH-2, 32'h0, 32'h0, 1, 2);
    dir("lh_top", 0, 0, 2'd1, 0, DEPTH-2, 32'h0, 32'h0, 0, 2);
    dir("lb_top", 0, 0, 2'd0, 0, DEPTH-1, 32'h0, 32'h0, 0, 2);
    dir("rsvd",  0, 0, 2'd3, 0, 'h080, 32'h0, 32'h0, 1, 2);

    // Backpressure: second request must wait for the handshake.
    resp_ready = 1'b0; sel = 1'b0;
    req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = AW'('h080); req_valid = 1'b1;
    @(posedge clk); #1;
    req_size = 2'd0;
    n = 0;
    while (!a_valid && n < 50) begin @(posedge clk); #1; n++; end
    chk("bp_first", a_rdata, 32'h889911BB);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", {31'd0, a_valid}, 32'd1);
      chk("bp_stable", a_rdata, 32'h889911BB);
      chk("bp_ready", {31'd0, a_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_hs", {30'd0, a_valid, a_ready}, 32'd1);
    @(posedge clk); #1;
    chk("bp_accept", {31'd0, a_ready}, 32'd0);
    req_valid = 1'b0;
    n = 0;
    while (!a_valid && n < 50) begin @(posedge clk); #1; n++; end
    chk("bp_second", a_rdata, 32'h000000BB);
    @(posedge clk); #1;

    // Randomized traffic against the model.
    for (int i = 0; i < 80; i++) begin
      addr = ($urandom_range(0, 3) == 0) ? (DEPTH - 8 + int'($urandom_range(0, 7)))
                                          : int'($urandom_range(0, 63));
      size = 2'($urandom_range(0, 3));
      do_req(0, 1'($urandom), size, 1'($urandom), addr, $urandom, rd, e, lat, mrd, me);
      chk("rnd_rdata", rd, mrd);
      chk("rnd_err", {31'd0, e}, {31'd0, me});
    end

    // Reset during WAIT drops the store.
    sel = 1'b0; req_we = 1'b1; req_size = 2'd2; req_addr = AW'('h100);
    req_wdata = 32'hDEADBEEF; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rstw_outputs", {a_valid, a_err, a_rdata[29:0]}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rstw_ready", {31'd0, a_ready}, 32'd1);
    dir("lw100", 0, 0, 2'd2, 0, 'h100, 32'h0, 32'h0, 0, 2);

    // Reset during RESP keeps the committed store.
    resp_ready = 1'b0;
    req_we = 1'b1; req_size = 2'd2; req_addr = AW'('h104); req_wdata = 32'h12345678; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!a_valid && n < 50) begin @(posedge clk); #1; n++; end
    chk("rstr_resp", {31'd0, a_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstr_drop", {31'd0, a_valid}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    resp_ready = 1'b1;
    ref_access(1, 2'd2, 0, 'h104, 32'h12345678, mrd, me);
    @(posedge clk); #1;
    dir("lw104", 0, 0, 2'd2, 0, 'h104, 32'h0, 32'h12345678, 0, 2);

    // WAIT = 0 instance: response in the cycle after accept.
    dir("w0_sw", 1, 1, 2'd2, 0, 'h010, 32'hCAFEF00D, 32'h0, 0, 0);
    dir("w0_lw", 1, 0, 2'd2, 0, 'h010, 32'h0, 32'hCAFEF00D, 0, 0);
    dir("w0_lh", 1, 0, 2'd1, 1, 'h012, 32'h0, 32'hFFFFCAFE, 0, 0);
    dir("w0_err", 1, 0, 2'd2, 0, 'h012, 32'h0, 32'h0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
